// File: rtl/rssb_sequencer.sv
// rssb_sequencer: fetch/load/write control sequencer for the single-instruction RSSB core
module rssb_sequencer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              halted,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_out,
  output logic [WIDTH-1:0]  acc_out
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, HALT} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, opa, opa_nx, addr_nx;
  logic [WIDTH-1:0]  acc, acc_nx, opd, opd_nx, wdata_nx, diff;
  logic              req_nx, we_nx, retire_nx, borrow;
  assign diff    = opd - acc;
  assign borrow  = opd < acc;
  assign busy    = state inside {FETCH, LOAD, WRITE};
  assign halted  = state == HALT;
  assign pc_out  = pc;
  assign acc_out = acc;
  // next state and next registered outputs; each state issues one transaction and waits for its ack
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    acc_nx    = acc;
    opa_nx    = opa;
    opd_nx    = opd;
    req_nx    = mem_req;
    we_nx     = mem_we;
    addr_nx   = mem_addr;
    wdata_nx  = mem_wdata;
    retire_nx = 1'b0;
    case (state)
      IDLE, HALT: if (start) begin
        state_nx = FETCH;
        pc_nx    = '0;
        acc_nx   = '0;
      end
      FETCH: if (!mem_req) begin
        req_nx  = 1'b1;
        we_nx   = 1'b0;
        addr_nx = pc;
      end else if (mem_ack) begin
        req_nx   = 1'b0;
        opa_nx   = mem_rdata[ADDR_W-1:0];
        state_nx = &mem_rdata ? HALT : LOAD;
      end
      LOAD: if (opa == '0) begin
        opd_nx   = WIDTH'(pc);
        state_nx = WRITE;
      end else if (!mem_req) begin
        req_nx  = 1'b1;
        we_nx   = 1'b0;
        addr_nx = opa;
      end else if (mem_ack) begin
        req_nx   = 1'b0;
        opd_nx   = mem_rdata;
        state_nx = WRITE;
      end
      WRITE: if (opa == '0) begin
        acc_nx    = diff;
        pc_nx     = diff[ADDR_W-1:0];
        retire_nx = 1'b1;
        state_nx  = FETCH;
      end else if (!mem_req) begin
        req_nx   = 1'b1;
        we_nx    = 1'b1;
        addr_nx  = opa;
        wdata_nx = diff;
      end else if (mem_ack) begin
        req_nx    = 1'b0;
        we_nx     = 1'b0;
        acc_nx    = diff;
        pc_nx     = pc + (borrow ? ADDR_W'(2) : ADDR_W'(1));
        retire_nx = 1'b1;
        state_nx  = FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state, architectural registers and registered memory-port outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= '0;
      acc       <= '0;
      opa       <= '0;
      opd       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      acc       <= acc_nx;
      opa       <= opa_nx;
      opd       <= opd_nx;
      mem_req   <= req_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      retire    <= retire_nx;
    end
  end
endmodule

// File: tb/tb_rssb_sequencer.sv
// tb_rssb_sequencer: table-driven, directed and randomized checks of rssb_sequencer against an ISA-level model
module tb_rssb_sequencer;
  localparam int W = 16;
  localparam int A = 8;
  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          mem_req, mem_we, mem_ack, busy, halted, retire;
  logic [A-1:0]  mem_addr, pc_out;
  logic [W-1:0]  mem_wdata, mem_rdata, acc_out;
  logic [W-1:0]  mem [256];
  logic [W-1:0]  prog [256];
  logic          load = 1'b0;
  int unsigned   wcnt = 0, lat_cur = 0, minlat = 0, maxlat = 0;
  int            txn_total = 0;
  rssb_sequencer #(.WIDTH(W), .ADDR_W(A)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .halted(halted), .retire(retire), .pc_out(pc_out), .acc_out(acc_out)
  );
  always #5 clock = ~clock;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack = mem_req && (wcnt >= lat_cur);
  // word memory with a per-transaction random latency between minlat and maxlat
  always @(posedge clock) begin
    if (load) mem <= prog;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_req && mem_ack) txn_total <= txn_total + 1;
    if (!mem_req || mem_ack) begin
      wcnt <= 0;
      lat_cur <= $urandom_range(maxlat, minlat);
    end else wcnt <= wcnt + 1;
  end
  int           checks = 0, failures = 0, ret_cnt = 0, txn_mark = 0;
  logic [W-1:0] ref_mem [256];
  logic [A-1:0] ref_pc = '0;
  logic [W-1:0] ref_acc = '0;
  logic         p_pend = 1'b0, p_done = 1'b0, p_we = 1'b0, p_halt = 1'b0;
  logic [A-1:0] p_addr = '0;
  logic [W-1:0] p_wdata = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic ref_step(output bit h, output int ntx);
    logic [W-1:0] ins, m, r;
    logic [A-1:0] a;
    ins = ref_mem[ref_pc];
    h = ins == 16'hFFFF;
    ntx = 1;
    if (!h) begin
      a = ins[A-1:0];
      m = (a == 0) ? W'(ref_pc) : ref_mem[a];
      r = m - ref_acc;
      if (a == 0) ref_pc = r[A-1:0];
      else begin
        ref_mem[a] = r;
        ref_pc = ref_pc + A'((m < ref_acc) ? 2 : 1);
        ntx = 3;
      end
      ref_acc = r;
    end
  endtask
  task automatic tick();
    bit h;
    int ntx;
    @(negedge clock);
    if (p_pend) chk("hold", 32'({mem_req, mem_we, mem_addr, (p_we ? mem_wdata : p_wdata)}),
                    32'({1'b1, p_we, p_addr, p_wdata}));
    if (p_done) chk("drop", 32'(mem_req), 32'(0));
    if (halted) chk("halt_noreq", 32'(mem_req), 32'(0));
    if (retire) begin
      ref_step(h, ntx);
      ret_cnt++;
      chk("ret_nohalt", 32'(h), 32'(0));
      chk("pc", 32'(pc_out), 32'(ref_pc));
      chk("acc", 32'(acc_out), 32'(ref_acc));
      chk("txns", txn_total - txn_mark, ntx);
      txn_mark = txn_total;
    end
    if (halted && !p_halt) begin
      ref_step(h, ntx);
      chk("halt_pred", 32'(h), 32'(1));
      chk("halt_busy", 32'(busy), 32'(0));
      chk("halt_pc", 32'(pc_out), 32'(ref_pc));
      chk("halt_txns", txn_total - txn_mark, 1);
      txn_mark = txn_total;
    end
    p_pend = mem_req && !mem_ack;
    p_done = mem_req && mem_ack;
    p_we = mem_we;
    p_addr = mem_addr;
    p_wdata = mem_wdata;
    p_halt = halted;
  endtask
  task automatic do_reset();
    p_pend = 1'b0;
    p_done = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("reset_state", 32'({mem_req, mem_we, retire, busy, halted, mem_addr, pc_out}), 32'(0));
    chk("reset_data", 32'({mem_wdata, acc_out}), 32'(0));
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    reset_n = 1'b1;
    txn_mark = txn_total;
  endtask
  task automatic pulse_start();
    if (!busy) begin
      ref_mem = mem;
      ref_pc = '0;
      ref_acc = '0;
      txn_mark = txn_total;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic run_until(input int nret, input int budget, input string name);
    int tgt, i;
    tgt = ret_cnt + nret;
    i = 0;
    while (i < budget && ret_cnt < tgt && !halted) begin
      tick();
      i++;
    end
    chk(name, 32'(i < budget), 32'(1));
  endtask
  task automatic fill(input logic [W-1:0] v);
    for (int i = 0; i < 256; i++) prog[i] = v;
  endtask
  typedef struct {
    logic [W-1:0] i0, i1, d0, d1, acc1, acc2, wv;
    logic [A-1:0] pc1, pc2, wa;
    int unsigned  lat;
  } vec_t;
  vec_t tbl [5];
  int n, bad;
  logic [W-1:0] v;
  initial begin
    tbl[0] = '{16'h0005, 16'h0006, 16'd10, 16'd3, 16'd10, 16'hFFF9, 16'hFFF9, 8'd1, 8'd3, 8'd6, 0};
    tbl[1] = '{16'h0005, 16'h0006, 16'd7, 16'd20, 16'd7, 16'd13, 16'd13, 8'd1, 8'd2, 8'd6, 1};
    tbl[2] = '{16'h0005, 16'h0000, 16'hFFFE, 16'd0, 16'hFFFE, 16'd3, 16'hFFFE, 8'd1, 8'd3, 8'd5, 3};
    tbl[3] = '{16'hFF05, 16'h0006, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 8'd1, 8'd2, 8'd6, 2};
    tbl[4] = '{16'h0000, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 0};
    tick();
    for (int k = 0; k < 5; k++) begin
      fill(16'hFFFF);
      prog[0] = tbl[k].i0;
      prog[1] = tbl[k].i1;
      if (tbl[k].i0[A-1:0] != 0) prog[tbl[k].i0[A-1:0]] = tbl[k].d0;
      if (tbl[k].i1[A-1:0] != 0) prog[tbl[k].i1[A-1:0]] = tbl[k].d1;
      minlat = tbl[k].lat;
      maxlat = tbl[k].lat;
      do_reset();
      pulse_start();
      run_until(1, 200, "tbl_run1");
      chk("tbl_acc1", 32'(acc_out), 32'(tbl[k].acc1));
      chk("tbl_pc1", 32'(pc_out), 32'(tbl[k].pc1));
      run_until(1, 200, "tbl_run2");
      chk("tbl_acc2", 32'(acc_out), 32'(tbl[k].acc2));
      chk("tbl_pc2", 32'(pc_out), 32'(tbl[k].pc2));
      chk("tbl_mem", 32'(mem[tbl[k].wa]), 32'(tbl[k].wv));
    end
    fill(16'hFFFF);
    prog[0] = 16'h0005;
    prog[5] = 16'd10;
    for (int k = 0; k < 2; k++) begin
      minlat = k == 0 ? 0 : 3;
      maxlat = minlat;
      do_reset();
      pulse_start();
      chk("first_busy", 32'(busy), 32'(1));
      chk("first_req_low", 32'(mem_req), 32'(0));
      n = 0;
      while (!retire && n < 40) begin
        tick();
        n++;
      end
      chk("latency", n, k == 0 ? 6 : 15);
      chk("c1_acc", 32'(acc_out), 32'd10);
      chk("c1_pc", 32'(pc_out), 32'd1);
      chk("c1_mem", 32'(mem[5]), 32'd10);
    end
    run_until(10, 200, "halt_wait");
    chk("halted", 32'({halted, busy}), 32'b10);
    chk("halt_pc_hold", 32'(pc_out), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    pulse_start();
    chk("restart", 32'({busy, halted, pc_out, acc_out}), 32'({1'b1, 1'b0, 8'd0, 16'd0}));
    run_until(1, 200, "restart_run");
    chk("restart_acc", 32'(acc_out), 32'd10);
    minlat = 3;
    maxlat = 3;
    do_reset();
    pulse_start();
    n = 0;
    while (!(mem_req && mem_we && !mem_ack) && n < 100) begin
      tick();
      n++;
    end
    chk("find_write", 32'(n < 100), 32'(1));
    #2;
    do_reset();
    fill(16'hFFFF);
    prog[0] = 16'h0005;
    prog[1] = 16'h0006;
    prog[5] = 16'd10;
    prog[6] = 16'd3;
    minlat = 0;
    maxlat = 2;
    do_reset();
    pulse_start();
    run_until(1, 200, "ign_run1");
    pulse_start();
    run_until(1, 200, "ign_run2");
    chk("ign_pc", 32'(pc_out), 32'd3);
    chk("ign_acc", 32'(acc_out), 32'hFFF9);
    fill(16'hFFFF);
    prog[0] = 16'h0010;
    prog[1] = 16'h0011;
    prog[2] = 16'h0012;
    prog[4] = 16'h0000;
    prog[6] = 16'h0013;
    prog[7] = 16'h0000;
    prog[8'hFF] = 16'h0014;
    prog[16'h10] = 16'h0000;
    prog[16'h11] = 16'hFFFE;
    prog[16'h12] = 16'hFFFC;
    prog[16'h13] = 16'h000E;
    prog[16'h14] = 16'hFFFF;
    do_reset();
    pulse_start();
    run_until(4, 400, "jump_run");
    chk("jump_pc", 32'(pc_out), 32'd6);
    chk("jump_acc", 32'(acc_out), 32'd6);
    run_until(2, 400, "wrap_pre");
    chk("wrap_pre_pc", 32'(pc_out), 32'hFF);
    run_until(1, 200, "wrap_run");
    chk("wrap_pc", 32'(pc_out), 32'd0);
    chk("wrap_acc", 32'(acc_out), 32'd0);
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 256; i++) begin
        v = 16'($urandom);
        if ($urandom_range(7, 0) == 0) v[A-1:0] = '0;
        if ($urandom_range(15, 0) == 0) v = 16'hFFFF;
        prog[i] = v;
      end
      minlat = $urandom_range(1, 0);
      maxlat = minlat + $urandom_range(3, 0);
      do_reset();
      pulse_start();
      n = 0;
      bad = ret_cnt + 30;
      while (n < 1500 && ret_cnt < bad && !halted) begin
        if (busy && $urandom_range(39, 0) == 0) pulse_start();
        else tick();
        n++;
      end
      chk("rnd_progress", 32'(n < 1500), 32'(1));
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("rnd_mem", bad, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
